// File: rtl/tff_updown_counter_pkg.sv
// Shared direction constants and the modulo next-count function for the T-FF counter.
// Latency: n/a (package).
// Backpressure: n/a.
package tff_updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One counting step inside 0..modulus-1; 32-bit math leaves headroom past WIDTH+1.
    function automatic int unsigned mod_next(input int unsigned cur,
                                             input logic        dir,
                                             input int unsigned modulus);
        int unsigned nxt;
        if (dir == DIR_UP) begin
            nxt = (cur >= modulus - 1) ? 0 : cur + 1;
        end else begin
            nxt = (cur == 0) ? modulus - 1 : cur - 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/tff_updown_counter_if.sv
// Control/status bundle between a counter and its driver.
// Latency: n/a (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface tff_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output enable, up, load, d,
        input  q, tc, wrap
    );

    modport slave (
        input  enable, up, load, d,
        output q, tc, wrap
    );
endinterface

// File: rtl/tff_updown_counter_tff_cell.sv
// Single toggle flip-flop with asynchronous active-low clear.
// Latency: q flips one clk edge after t is sampled high.
// Backpressure: none.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-MODULUS up/down counter with load; state held in T flip-flops driven by toggle masks.
// Latency: q and wrap update one edge after sampling; tc is combinational on q/enable/up.
// Backpressure: none; load > enable > hold is resolved every cycle.
module tff_updown_counter
    import tff_updown_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tff_updown_counter_if.slave  bus
);

    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_modulus
        $error("tff_updown_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] d_clamped;
    logic [WIDTH-1:0] t;
    logic             tc;
    logic             wrap_q;

    // tc doubles as the wrap-event flag whenever a count (not a load) happens.
    assign tc = bus.enable & ((bus.up == DIR_UP) ? (q == MAX_CNT) : (q == '0));

    assign q_step    = WIDTH'(mod_next(32'(q), bus.up, MODULUS));
    assign d_clamped = (32'(bus.d) > 32'(MODULUS - 1)) ? MAX_CNT : bus.d;

    always_comb begin
        q_next = q;
        if (bus.load) begin
            q_next = d_clamped;
        end else if (bus.enable) begin
            q_next = q_step;
        end
    end

    assign t = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= ~bus.load & tc;
        end
    end

    assign bus.q    = q;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_q;

endmodule

// File: doc/tff_updown_counter.md
Name: tff_updown_counter

Overview:
- Synchronous modulo-N up/down counter. Every state bit is held in a T flip-flop (toggle storage element).
- The next-state logic generates per-bit toggle enables rather than D values.
- It consumes toggle-style stimulus (t/enable) and extends the sequential toggle-element family into a usable counting stage.
- Output drives display/decoder stages downstream.

Parameters:
- WIDTH, 4, bit width of count register q.
- MODULUS, 10, count range 0..MODULUS-1. Legal range 2 ≤ MODULUS ≤ 2**WIDTH. Out-of-range values are a synthesis-time error.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  count enable; counter advances one step per clk edge while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load request.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational. Equals enable & (up ? q==MODULUS-1 : q==0).
- wrap  output  1  registered one-cycle pulse, high in the cycle after a wrap-around occurred.

Behaviour:
- Reset: rst_n low forces q=0 and wrap=0 immediately, independent of clk. Release is synchronous to the next clk edge; there is no counting on the edge where rst_n is sampled low.
- Reset asserted mid-count or mid-load aborts the operation; the state after release is q=0.
- Priority at each rising clk edge: load > enable > hold.
- Load:
  - load=1: q ← d when d ≤ MODULUS-1; otherwise q ← MODULUS-1 (clamp).
  - wrap ← 0. enable and up are ignored that cycle.
- Count up (load=0, enable=1, up=1): q ← q+1. If q==MODULUS-1, q ← 0 and wrap ← 1.
- Count down (load=0, enable=1, up=0): q ← q-1. If q==0, q ← MODULUS-1 and wrap ← 1.
- Hold (load=0, enable=0): q unchanged, wrap ← 0.
- wrap is high for exactly one cycle per wrap event. On consecutive wraps (e.g. MODULUS=2 counting continuously) it stays high on each such cycle.
- Toggle generation:
  - Compute q_next per the rules above; per-bit toggle t[i] = q[i] ^ q_next[i].
  - Each bit stores via a T flip-flop: q[i] toggles on clk edge when t[i]=1.
  - No D-style assignment of q outside reset.
- Latency:
  - q reflects a load/count decision one clk edge after inputs are sampled.
  - tc is combinational, valid in the same cycle as q.
  - wrap lags the wrapping edge by zero cycles; it is registered alongside q.
- Direction change: up may change any cycle. The new direction applies at the next edge; there is no dead cycle.
- Arithmetic: unsigned, WIDTH bits. Intermediate ±1 is computed in WIDTH+1 bits so no overflow escapes the modulus check.
- Power-of-two MODULUS behaves as a plain binary wrap with identical port semantics.

Decomposition:
- Shared package/include:
  - direction constants DIR_UP=1, DIR_DOWN=0;
  - a function computing modulo next-state (used by RTL and the bench reference model).
- One sub-module, tff_cell:
  - ports clk, rst_n, t, q;
  - asynchronous active-low clear;
  - toggles on rising clk when t=1.
  - Instantiated WIDTH times via generate.

Test Plan:
1. Reset: hold rst_n=0, toggle clk, enable=1 up=1 → q=0, wrap=0 throughout. Deassert mid-cycle → first increment only at the following edge (q=1).
2. Up count with wrap (WIDTH=4, MODULUS=10): enable=1, up=1 for 12 edges from 0 → q runs 1..9,0,1,2. tc=1 exactly while q=9. wrap=1 only in the cycle q=0 after 9.
3. Down count with wrap: load d=2, then enable=1 up=0 → q=2,1,0,9,8. tc=1 at q=0. wrap=1 in the cycle q=9.
4. Load priority and clamp: enable=1, load=1, d=4 → q=4 (no count that edge). load d=13 → q=9. load asserted on a would-be-wrap edge (q=9, up) with d=5 → q=5, wrap=0.
5. Direction flip and hold: count up to 5, set up=0 → next q=4. enable=0 for 3 edges → q stays 4, tc=0, wrap=0.
6. Async reset mid-operation: counting up at q=7, pulse rst_n low between edges → q=0 immediately (before next clk). After release, count resumes from 0.
